// File: rtl/shift_rows_pipe_if.sv
// Stream interface for the ShiftRows stage: an input side carrying one AES
// state plus its direction flag, and an output side carrying the shifted state.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid, data and inv stable until that edge.
// Ready may be high without valid and vice versa. Neither side may make valid
// depend on ready combinationally.
interface shift_rows_pipe_if #(
  parameter int NB = 4
);
  localparam int W = 32 * NB;

  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  // Side that feeds states in and consumes results.
  modport master (
    output in_valid,
    output in_inv,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Side implemented by the ShiftRows stage.
  modport slave (
    input  in_valid,
    input  in_inv,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8
// columns. The row rotation is pure wiring ahead of a 2-entry output FIFO;
// only the transformed state is stored.
module shift_rows_pipe #(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_rows_pipe_if.slave bus
);
  localparam int W = 32 * NB;

  // Reject block widths that Rijndael does not define for this stage.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Row rotation amount: 0,1,2,3 for NB 4/6; 0,1,3,4 for NB 8.
  function automatic int row_off(input int r);
    if (NB == 8) begin
      return (r < 2) ? r : r + 1;
    end
    return r;
  endfunction

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted;

  // Byte i sits at bits [W-1-8i -: 8] with column i/4 and row i%4.
  // Forward reads column (c+off) mod NB, inverse reads (c-off) mod NB.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF   = row_off(r);
      localparam int DST   = W - 1 - 8 * (4 * c + r);
      localparam int SRC_F = W - 1 - 8 * (4 * ((c + OFF) % NB) + r);
      localparam int SRC_I = W - 1 - 8 * (4 * ((c - OFF + NB) % NB) + r);
      assign fwd_data[DST -: 8] = bus.in_data[SRC_F -: 8];
      assign inv_data[DST -: 8] = bus.in_data[SRC_I -: 8];
    end
  end

  // Direction is chosen per transfer, so mixed streams need no flush.
  assign shifted = bus.in_inv ? inv_data : fwd_data;

  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0][W-1:0] mem;
  logic              push;
  logic              pop;

  // Ready comes from the occupancy register only, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Occupancy and pointer bookkeeping; pointers wrap naturally at 1 bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage clears on reset so out_data reads zero until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (push) begin
      mem[wr_ptr] <= shifted;
    end
  end
endmodule
